// File: rtl/pe_result_drain.sv
// pe_result_drain: consumer end of the pe_mac result interface.
// Captures the accumulator vector into a two-entry ping-pong buffer,
// pulses o_mac_clear, then streams each vector to writeback either raw
// (two beats of 2*DATA_WIDTH lanes) or requantized (one beat of
// DATA_WIDTH lanes, round-half-up then saturate).
//
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_mac_result     DATA_NUM signed accumulator lanes
//   i_result_vld     capture request
//   o_result_rdy     a buffer entry is free
//   o_mac_clear      one-cycle clear pulse after each capture
//   i_quant_en       1 = requantize, 0 = raw (sampled at capture)
//   i_shift          requant right shift (sampled at capture)
//   o_data           output beat
//   o_data_vld       beat valid
//   i_data_rdy       downstream ready
//   o_data_last      final beat of a vector
//   o_buf_cnt        occupied buffer entries (0..2)
//
// Build option: define PE_DRAIN_RELU_EN to clamp negative lanes to
// zero before packing or requantization.

module pe_result_drain #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_NUM   = 32
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [DATA_NUM*2*DATA_WIDTH-1:0] i_mac_result,
   input  logic                             i_result_vld,
   output logic                             o_result_rdy,
   output logic                             o_mac_clear,
   input  logic                             i_quant_en,
   input  logic [3:0]                       i_shift,
   output logic [DATA_NUM*DATA_WIDTH-1:0]   o_data,
   output logic                             o_data_vld,
   input  logic                             i_data_rdy,
   output logic                             o_data_last,
   output logic [1:0]                       o_buf_cnt
);

   localparam int ACC_W = 2 * DATA_WIDTH;
   localparam int VEC_W = DATA_NUM * ACC_W;
   localparam int OUT_W = DATA_NUM * DATA_WIDTH;
   localparam int HALF  = DATA_NUM / 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_t;

   state_t           state;
   logic [VEC_W-1:0] buf_vec [2];
   logic [3:0]       buf_sh  [2];
   logic [1:0]       buf_q;
   logic             head;
   logic             tail;

   logic             cap;
   logic             pop;
   logic             more;
   logic             h_q;
   logic             n_q;
   logic [OUT_W-1:0] h_b0;
   logic [OUT_W-1:0] h_b1;
   logic [OUT_W-1:0] n_b0;

   // Optional negative-lane clamp.
   function automatic logic [ACC_W-1:0] lane_fix(
      input logic [ACC_W-1:0] a
   );
`ifdef PE_DRAIN_RELU_EN
      lane_fix = a[ACC_W-1] ? '0 : a;
`else
      lane_fix = a;
`endif
   endfunction

   // Round-half-up shift in ACC_W+1 bits (cannot overflow), then
   // saturate to the signed DATA_WIDTH range.
   function automatic logic [DATA_WIDTH-1:0] quant_lane(
      input logic [ACC_W-1:0] a,
      input logic [3:0]       sh
   );
      logic signed [ACC_W:0] x;
      logic signed [ACC_W:0] rnd;
      logic signed [ACC_W:0] r;
      logic signed [ACC_W:0] maxv;
      logic signed [ACC_W:0] minv;
      maxv = $signed({{(ACC_W-DATA_WIDTH+2){1'b0}},
                      {(DATA_WIDTH-1){1'b1}}});
      minv = ~maxv;
      x    = $signed({a[ACC_W-1], a});
      rnd  = '0;
      if (sh != 4'd0) begin
         rnd[sh-4'd1] = 1'b1;
      end
      r = (x + rnd) >>> sh;
      if (r > maxv) begin
         quant_lane = maxv[DATA_WIDTH-1:0];
      end else if (r < minv) begin
         quant_lane = minv[DATA_WIDTH-1:0];
      end else begin
         quant_lane = r[DATA_WIDTH-1:0];
      end
   endfunction

   // Build one output beat of an entry; hi selects raw beat1.
   function automatic logic [OUT_W-1:0] pack_beat(
      input logic [VEC_W-1:0] v,
      input logic             q,
      input logic [3:0]       sh,
      input logic             hi
   );
      logic [OUT_W-1:0] d;
      logic [ACC_W-1:0] a;
      int               base;
      d    = '0;
      base = hi ? HALF : 0;
      if (q) begin
         for (int k = 0; k < DATA_NUM; k++) begin
            a = lane_fix(v[k*ACC_W +: ACC_W]);
            d[k*DATA_WIDTH +: DATA_WIDTH] = quant_lane(a, sh);
         end
      end else begin
         for (int k = 0; k < HALF; k++) begin
            a = lane_fix(v[(k+base)*ACC_W +: ACC_W]);
            d[k*ACC_W +: ACC_W] = a;
         end
      end
      pack_beat = d;
   endfunction

   assign o_result_rdy = (o_buf_cnt != 2'd2);
   assign cap          = i_result_vld && o_result_rdy;
   // The other entry is only loadable if it was already counted.
   assign more         = (o_buf_cnt == 2'd2);

   always_comb begin
      h_q  = buf_q[head];
      n_q  = buf_q[~head];
      h_b0 = pack_beat(buf_vec[head], h_q, buf_sh[head], 1'b0);
      h_b1 = pack_beat(buf_vec[head], h_q, buf_sh[head], 1'b1);
      n_b0 = pack_beat(buf_vec[~head], n_q, buf_sh[~head], 1'b0);
      pop  = 1'b0;
      if (i_data_rdy) begin
         pop = ((state == BEAT0) && h_q) || (state == BEAT1);
      end
   end

   // Buffer storage and pointers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 2; i++) begin
            buf_vec[i] <= '0;
            buf_sh[i]  <= '0;
         end
         buf_q       <= '0;
         head        <= 1'b0;
         tail        <= 1'b0;
         o_buf_cnt   <= 2'd0;
         o_mac_clear <= 1'b0;
      end else begin
         o_mac_clear <= cap;
         if (cap) begin
            buf_vec[tail] <= i_mac_result;
            buf_sh[tail]  <= i_shift;
            buf_q[tail]   <= i_quant_en;
            tail          <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         o_buf_cnt <= o_buf_cnt + {1'b0, cap} - {1'b0, pop};
      end
   end

   // Output FSM; all outputs registered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         o_data      <= '0;
         o_data_vld  <= 1'b0;
         o_data_last <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (o_buf_cnt != 2'd0) begin
                  o_data      <= h_b0;
                  o_data_vld  <= 1'b1;
                  o_data_last <= h_q;
                  state       <= BEAT0;
               end
            end
            BEAT0, BEAT1: begin
               if (i_data_rdy) begin
                  if (state == BEAT0 && !h_q) begin
                     o_data      <= h_b1;
                     o_data_last <= 1'b1;
                     state       <= BEAT1;
                  end else if (more) begin
                     o_data      <= n_b0;
                     o_data_last <= n_q;
                     state       <= BEAT0;
                  end else begin
                     o_data_vld  <= 1'b0;
                     o_data_last <= 1'b0;
                     state       <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
